// File: rtl/vga_if.sv
// rtl/vga_if.sv - VGA raster bus from the timing source to the renderers
interface vga_if #(
    parameter int HCOUNT_WIDTH = 10,
    parameter int VCOUNT_WIDTH = 10
);
    logic [HCOUNT_WIDTH-1:0] hcount;
    logic [VCOUNT_WIDTH-1:0] vcount;
    logic                    hsync;
    logic                    vsync;
    logic                    blank;

    modport src (output hcount, vcount, hsync, vsync, blank);
    modport dst (input  hcount, vcount, hsync, vsync, blank);
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 raster timing source with pixel clock-enable divider
// VGA_FRAME_CNT_EN: when defined, frame_cnt_out counts completed frames; otherwise it is tied to 0.
module vga_timing_gen #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int CLK_DIV      = 1,
    parameter int HCOUNT_WIDTH = 10,
    parameter int VCOUNT_WIDTH = 10
) (
    input  logic        clk_in,
    input  logic        rst_in,
    vga_if.src          vga,
    output logic        pix_en_out,
    output logic        line_start_out,
    output logic        frame_start_out,
    output logic [15:0] frame_cnt_out
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HCOUNT_WIDTH-1:0] H_LAST = HCOUNT_WIDTH'(H_TOTAL - 1);
    localparam logic [VCOUNT_WIDTH-1:0] V_LAST = VCOUNT_WIDTH'(V_TOTAL - 1);
    localparam logic [HCOUNT_WIDTH-1:0] H_ONE  = HCOUNT_WIDTH'(1);
    localparam logic [VCOUNT_WIDTH-1:0] V_ONE  = VCOUNT_WIDTH'(1);
    localparam logic [3:0]              DIV_LAST = 4'(CLK_DIV - 1);

    localparam logic [31:0] HS_START  = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_END    = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] VS_START  = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_END    = 32'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [31:0] H_VISIBLE = 32'(H_ACTIVE);
    localparam logic [31:0] V_VISIBLE = 32'(V_ACTIVE);

    if (H_TOTAL > 2**HCOUNT_WIDTH) begin : g_hwidth_err
        $error("H_TOTAL does not fit in HCOUNT_WIDTH bits");
    end
    if (V_TOTAL > 2**VCOUNT_WIDTH) begin : g_vwidth_err
        $error("V_TOTAL does not fit in VCOUNT_WIDTH bits");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_err
        $error("CLK_DIV must be in 1..16");
    end

    logic [3:0]              div_cnt_q, div_cnt_d;
    logic [HCOUNT_WIDTH-1:0] hcount_q, hcount_d;
    logic [VCOUNT_WIDTH-1:0] vcount_q, vcount_d;
    logic                    hsync_q, hsync_d;
    logic                    vsync_q, vsync_d;
    logic                    blank_q, blank_d;
    logic                    pix_en;
    logic [31:0]             h_ext, v_ext;

    always_comb begin
        pix_en    = (div_cnt_q == DIV_LAST);
        div_cnt_d = pix_en ? 4'd0 : div_cnt_q + 4'd1;
        hcount_d  = hcount_q;
        vcount_d  = vcount_q;
        if (pix_en) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + V_ONE;
            end else begin
                hcount_d = hcount_q + H_ONE;
            end
        end
        // Sync/blank decode from the next counts so they land on the same edge as the counters.
        h_ext   = 32'(hcount_d);
        v_ext   = 32'(vcount_d);
        hsync_d = !(h_ext >= HS_START && h_ext < HS_END);
        vsync_d = !(v_ext >= VS_START && v_ext < VS_END);
        blank_d = (h_ext >= H_VISIBLE) || (v_ext >= V_VISIBLE);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            div_cnt_q <= 4'd0;
            hcount_q  <= '0;
            vcount_q  <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            blank_q   <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            hcount_q  <= hcount_d;
            vcount_q  <= vcount_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            blank_q   <= blank_d;
        end
    end

    assign vga.hcount      = hcount_q;
    assign vga.vcount      = vcount_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.blank       = blank_q;
    assign pix_en_out      = pix_en;
    assign line_start_out  = pix_en && (hcount_q == '0);
    assign frame_start_out = pix_en && (hcount_q == '0) && (vcount_q == '0);

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        frame_wrap;

    always_comb begin
        frame_wrap  = pix_en && (hcount_q == H_LAST) && (vcount_q == V_LAST);
        frame_cnt_d = frame_wrap ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            frame_cnt_q <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt_out = frame_cnt_q;
`else
    assign frame_cnt_out = 16'd0;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed checks of vga_timing_gen at full size, reduced size and CLK_DIV=4
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Reduced raster: 24 clocks/line, 16 lines/frame, 384 pixels/frame.
    vga_if #(.HCOUNT_WIDTH(5), .VCOUNT_WIDTH(4)) vi1 ();
    vga_if #(.HCOUNT_WIDTH(5), .VCOUNT_WIDTH(4)) vi4 ();
    vga_if #(.HCOUNT_WIDTH(10), .VCOUNT_WIDTH(10)) vid ();

    logic        pe1, ls1, fs1, pe4, ls4, fs4, ped, lsd, fsd;
    logic [15:0] fc1, fc4, fcd;

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .CLK_DIV(1), .HCOUNT_WIDTH(5), .VCOUNT_WIDTH(4)
    ) dut1 (
        .clk_in(clk), .rst_in(rst), .vga(vi1), .pix_en_out(pe1),
        .line_start_out(ls1), .frame_start_out(fs1), .frame_cnt_out(fc1)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .CLK_DIV(4), .HCOUNT_WIDTH(5), .VCOUNT_WIDTH(4)
    ) dut4 (
        .clk_in(clk), .rst_in(rst), .vga(vi4), .pix_en_out(pe4),
        .line_start_out(ls4), .frame_start_out(fs4), .frame_cnt_out(fc4)
    );

    vga_timing_gen dutd (
        .clk_in(clk), .rst_in(rst), .vga(vid), .pix_en_out(ped),
        .line_start_out(lsd), .frame_start_out(fsd), .frame_cnt_out(fcd)
    );

    typedef struct {
        int cyc;
        int sel;
        int h;
        int v;
        bit hs;
        bit vs;
        bit bl;
        bit ls;
        bit fs;
    } vec_t;

    vec_t tbl[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input vec_t e);
        int h, v, hs, vs, bl, ls, fs;
        string tag;
        case (e.sel)
            1: begin h = int'(vi1.hcount); v = int'(vi1.vcount); hs = int'(vi1.hsync);
                     vs = int'(vi1.vsync); bl = int'(vi1.blank); ls = int'(ls1); fs = int'(fs1); end
            4: begin h = int'(vi4.hcount); v = int'(vi4.vcount); hs = int'(vi4.hsync);
                     vs = int'(vi4.vsync); bl = int'(vi4.blank); ls = int'(ls4); fs = int'(fs4); end
            default: begin h = int'(vid.hcount); v = int'(vid.vcount); hs = int'(vid.hsync);
                     vs = int'(vid.vsync); bl = int'(vid.blank); ls = int'(lsd); fs = int'(fsd); end
        endcase
        tag = $sformatf("dut%0d@%0d", e.sel, e.cyc);
        chk({tag, " hcount"}, h, e.h);
        chk({tag, " vcount"}, v, e.v);
        chk({tag, " hsync"}, hs, int'(e.hs));
        chk({tag, " vsync"}, vs, int'(e.vs));
        chk({tag, " blank"}, bl, int'(e.bl));
        chk({tag, " line_start"}, ls, int'(e.ls));
        chk({tag, " frame_start"}, fs, int'(e.fs));
    endtask

    initial begin
        int e_pe1 = 0, e_pe4 = 0, e_ls1 = 0, e_fs1 = 0, e_ls4 = 0, e_fs4 = 0;
        int e_lsd = 0, e_fsd = 0, e_h4 = 0, e_fc = 0;
        int vs_low = 0, hs_low = 0, exp_fc, waited;
        bit found;

        //                cyc sel   h   v hs vs bl ls fs
        tbl.push_back('{   0, 1,   0,  0, 1, 1, 0, 1, 1});
        tbl.push_back('{  15, 1,  15,  0, 1, 1, 0, 0, 0});
        tbl.push_back('{  16, 1,  16,  0, 1, 1, 1, 0, 0});
        tbl.push_back('{  17, 1,  17,  0, 1, 1, 1, 0, 0});
        tbl.push_back('{  18, 1,  18,  0, 0, 1, 1, 0, 0});
        tbl.push_back('{  20, 1,  20,  0, 0, 1, 1, 0, 0});
        tbl.push_back('{  21, 1,  21,  0, 1, 1, 1, 0, 0});
        tbl.push_back('{  23, 1,  23,  0, 1, 1, 1, 0, 0});
        tbl.push_back('{  24, 1,   0,  1, 1, 1, 0, 1, 0});
        tbl.push_back('{ 231, 1,  15,  9, 1, 1, 0, 0, 0});
        tbl.push_back('{ 240, 1,   0, 10, 1, 1, 1, 1, 0});
        tbl.push_back('{ 288, 1,   0, 12, 1, 0, 1, 1, 0});
        tbl.push_back('{ 306, 1,  18, 12, 0, 0, 1, 0, 0});
        tbl.push_back('{ 335, 1,  23, 13, 1, 0, 1, 0, 0});
        tbl.push_back('{ 336, 1,   0, 14, 1, 1, 1, 1, 0});
        tbl.push_back('{ 383, 1,  23, 15, 1, 1, 1, 0, 0});
        tbl.push_back('{ 384, 1,   0,  0, 1, 1, 0, 1, 1});
        tbl.push_back('{ 409, 1,   1,  1, 1, 1, 0, 0, 0});
        tbl.push_back('{   0, 4,   0,  0, 1, 1, 0, 0, 0});
        tbl.push_back('{   3, 4,   0,  0, 1, 1, 0, 1, 1});
        tbl.push_back('{   4, 4,   1,  0, 1, 1, 0, 0, 0});
        tbl.push_back('{   7, 4,   1,  0, 1, 1, 0, 0, 0});
        tbl.push_back('{  64, 4,  16,  0, 1, 1, 1, 0, 0});
        tbl.push_back('{1536, 4,   0,  0, 1, 1, 0, 0, 0});
        tbl.push_back('{1539, 4,   0,  0, 1, 1, 0, 1, 1});
        tbl.push_back('{   0, 0,   0,  0, 1, 1, 0, 1, 1});
        tbl.push_back('{ 639, 0, 639,  0, 1, 1, 0, 0, 0});
        tbl.push_back('{ 640, 0, 640,  0, 1, 1, 1, 0, 0});
        tbl.push_back('{ 655, 0, 655,  0, 1, 1, 1, 0, 0});
        tbl.push_back('{ 656, 0, 656,  0, 0, 1, 1, 0, 0});
        tbl.push_back('{ 751, 0, 751,  0, 0, 1, 1, 0, 0});
        tbl.push_back('{ 752, 0, 752,  0, 1, 1, 1, 0, 0});
        tbl.push_back('{ 799, 0, 799,  0, 1, 1, 1, 0, 0});
        tbl.push_back('{ 800, 0,   0,  1, 1, 1, 0, 1, 0});

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 0; k < 1600; k++) begin
            foreach (tbl[i]) if (tbl[i].cyc == k) check_vec(tbl[i]);
            if (pe1 !== 1'b1) e_pe1++;
            if (pe4 !== ((k % 4) == 3)) e_pe4++;
            if (ls1 !== ((k % 24) == 0)) e_ls1++;
            if (fs1 !== ((k % 384) == 0)) e_fs1++;
            if (ls4 !== (((k % 4) == 3) && (((k / 4) % 24) == 0))) e_ls4++;
            if (fs4 !== ((k % 1536) == 3)) e_fs4++;
            if (lsd !== ((k % 800) == 0)) e_lsd++;
            if (fsd !== (k == 0)) e_fsd++;
            if (int'(vi4.hcount) != ((k / 4) % 24)) e_h4++;
`ifdef VGA_FRAME_CNT_EN
            exp_fc = k / 384;
`else
            exp_fc = 0;
`endif
            if (int'(fc1) != exp_fc || int'(fcd) != 0) e_fc++;
            if (k < 384 && vi1.vsync == 1'b0) vs_low++;
            if (k < 384 && vi1.hsync == 1'b0) hs_low++;
            step();
        end

        chk("pix_en_div1_errors", e_pe1, 0);
        chk("pix_en_div4_errors", e_pe4, 0);
        chk("line_start_div1_errors", e_ls1, 0);
        chk("frame_start_div1_errors", e_fs1, 0);
        chk("line_start_div4_errors", e_ls4, 0);
        chk("frame_start_div4_errors", e_fs4, 0);
        chk("line_start_full_errors", e_lsd, 0);
        chk("frame_start_full_errors", e_fsd, 0);
        chk("hcount_hold_div4_errors", e_h4, 0);
        chk("frame_cnt_errors", e_fc, 0);
        chk("vsync_low_clocks", vs_low, 48);
        chk("hsync_low_clocks", hs_low, 48);

        found = 1'b0;
        waited = 0;
        while (!found && waited < 1000) begin
            if (int'(vi1.hcount) == 10 && int'(vi1.vcount) == 5) found = 1'b1;
            else begin
                step();
                waited++;
            end
        end
        chk("reach_h10_v5", int'(found), 1);

        rst = 1'b1;
        step();
        chk("midrst hcount", int'(vi1.hcount), 0);
        chk("midrst vcount", int'(vi1.vcount), 0);
        chk("midrst hsync", int'(vi1.hsync), 1);
        chk("midrst vsync", int'(vi1.vsync), 1);
        chk("midrst blank", int'(vi1.blank), 0);
        chk("midrst frame_cnt", int'(fc1), 0);
        rst = 1'b0;
        chk("restart frame_start", int'(fs1), 1);
        step();
        chk("restart hcount", int'(vi1.hcount), 1);
        chk("restart vcount", int'(vi1.vcount), 0);
        repeat (23) step();
        chk("restart line2 hcount", int'(vi1.hcount), 0);
        chk("restart line2 vcount", int'(vi1.vcount), 1);
        chk("restart line2 line_start", int'(ls1), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Source end of the VGA interface: drives the `vga_if.src` modport that all renderers consume through `vga_if.dst` (board, cursor, statistics graph).
- Generates the 640x480@60 raster: hcount, vcount, active-low hsync/vsync, and blank.
- A clock-enable divider lets the block run from a system clock faster than the pixel clock.
- Also emits frame-start and line-start strobes for frame-synchronous logic such as game-step and graph sampling.

Parameters:
- H_ACTIVE, 640, visible pixels per line (equals SCREEN_WIDTH)
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, hsync pulse width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_ACTIVE, 480, visible lines (equals SCREEN_HEIGHT)
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vsync pulse width, in lines
- V_BP, 33, vertical back porch, in lines
- CLK_DIV, 1, system clocks per pixel (1..16)

Ports:
- clk_in  input  1  system clock; all state changes on its rising edge
- rst_in  input  1  synchronous, active-high reset
- vga  output  vga_if.src  hcount[HCOUNT_WIDTH], vcount[VCOUNT_WIDTH], hsync, vsync, blank
- pix_en_out  output  1  pixel-advance strobe; counters step on the edge following its assertion
- line_start_out  output  1  one-clock pulse qualifying pixel (0, vcount)
- frame_start_out  output  1  one-clock pulse qualifying pixel (0, 0)
- frame_cnt_out  output  16  frame counter (see Optional Feature)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider:
  - div_cnt counts 0..CLK_DIV-1, then wraps to 0.
  - pix_en_out = (div_cnt == CLK_DIV-1), decoded combinationally from the register.
  - With CLK_DIV=1, pix_en_out is constantly 1 outside reset.
- Horizontal counter:
  - On a clock with pix_en_out=1, hcount increments.
  - When hcount == H_TOTAL-1, it wraps to 0 and vcount advances.
- Vertical counter: vcount wraps from V_TOTAL-1 to 0.
- Clocks with pix_en_out=0: all counters hold.
- hsync, vsync, blank:
  - Registered; updated in the same edge as the counters, so they always match the current hcount/vcount (zero relative latency).
  - hsync = 0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vsync = 0 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
  - blank = 1 iff hcount >= H_ACTIVE or vcount >= V_ACTIVE.
- Strobes:
  - line_start_out = pix_en_out && hcount==0.
  - frame_start_out = pix_en_out && hcount==0 && vcount==0.
  - Each is exactly one clock wide per line or per frame, independent of CLK_DIV.
- Reset values:
  - div_cnt=0, hcount=0, vcount=0.
  - hsync=1, vsync=1, blank=0.
  - frame_cnt_out=0.
  - Strobes follow from the equations above: with CLK_DIV=1, the first cycle after reset release shows frame_start_out=1.
- Reset mid-frame:
  - All state returns to reset values on the next edge; no partial line is completed.
  - Reset dominates pix_en_out.
- Width rule:
  - Counter registers are HCOUNT_WIDTH / VCOUNT_WIDTH bits, zero-extended on compare.
  - Totals must fit: H_TOTAL <= 2**HCOUNT_WIDTH and V_TOTAL <= 2**VCOUNT_WIDTH. Elaboration-time assertion on each.
  - Elaboration-time assertion that CLK_DIV is in 1..16.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined: frame_cnt_out increments by 1 on the edge where (hcount, vcount) wraps from (H_TOTAL-1, V_TOTAL-1) to (0,0). It wraps 65535 -> 0 and is cleared by rst_in.
- Undefined: no counter register is synthesized; frame_cnt_out is tied to 16'd0. The port list is identical in both builds.

Test Plan:
- CLK_DIV=1, release reset, run 420000 clocks:
  - frame_start_out pulses exactly at clock 0 and clock 420000 (800*525).
  - line_start_out pulses every 800 clocks.
- CLK_DIV=1, first line:
  - hsync low for hcount 656..751 (96 clocks).
  - blank low for hcount 0..639 and high for 640..799.
  - hcount wraps 799 -> 0 with vcount 0 -> 1.
- CLK_DIV=1, vertical:
  - vsync low only while vcount is 490..491 (1600 clocks).
  - blank high for all of vcount 480..524.
  - vcount wraps 524 -> 0.
- CLK_DIV=4:
  - pix_en_out is high one clock in four.
  - hcount holds for 4 clocks per value.
  - frame_start_out is one clock wide, with period 1680000.
- Assert rst_in for one clock at hcount=300, vcount=200:
  - Next edge shows hcount=0, vcount=0, hsync=1, vsync=1, blank=0.
  - Raster restarts cleanly.
- VGA_FRAME_CNT_EN defined: after 3 full frames, frame_cnt_out=3; preloaded at 65535 across one wrap, it reads 0.
- VGA_FRAME_CNT_EN undefined: frame_cnt_out stays 0 throughout.
